// File: rtl/alu_pkg.sv
// Shared constants and the issue-entry type for the ALU decode/issue stage.
// Opcode encodings follow the MIPS-I integer subset handled by the ALU.
package alu_pkg;

    localparam logic [3:0] ALUOP_AND = 4'b0000;
    localparam logic [3:0] ALUOP_OR  = 4'b0001;
    localparam logic [3:0] ALUOP_ADD = 4'b0010;
    localparam logic [3:0] ALUOP_SUB = 4'b0011;
    localparam logic [3:0] ALUOP_SLT = 4'b0100;
    localparam logic [3:0] ALUOP_NOR = 4'b0101;
    localparam logic [3:0] ALUOP_XOR = 4'b0110;
    localparam logic [3:0] ALUOP_SLL = 4'b0111;
    localparam logic [3:0] ALUOP_SRL = 4'b1000;
    localparam logic [3:0] ALUOP_SRA = 4'b1001;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  aluop;
        logic [4:0]  dst;
        logic        wen;
        logic        illegal;
    } issue_entry_t;

    function automatic logic [31:0] sext16(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

    function automatic logic [31:0] zext16(input logic [15:0] imm);
        return {16'h0000, imm};
    endfunction

endpackage

// File: rtl/alu_issue_stage_if.sv
// Producer-side and consumer-side handshake bundle of the issue stage.
// slave = the stage itself, master = the surrounding fetch/execute logic.
interface alu_issue_stage_if;

    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_rs_data;
    logic [31:0] in_rt_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_a;
    logic [31:0] out_b;
    logic [3:0]  out_aluop;
    logic [4:0]  out_dst;
    logic        out_wen;
    logic        out_illegal;

    modport slave (
        input  in_valid, in_instr, in_rs_data, in_rt_data, out_ready,
        output in_ready, out_valid, out_a, out_b, out_aluop, out_dst, out_wen, out_illegal
    );

    modport master (
        output in_valid, in_instr, in_rs_data, in_rt_data, out_ready,
        input  in_ready, out_valid, out_a, out_b, out_aluop, out_dst, out_wen, out_illegal
    );

endinterface

// File: rtl/alu_op_decode.sv
// Combinational MIPS decode: instruction word plus GPR read data into one issue entry.
// Unsupported encodings still produce an entry, flagged illegal with all payload zeroed.
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [31:0]  i_instr,
    input  logic [31:0]  i_rs_data,
    input  logic [31:0]  i_rt_data,
    output issue_entry_t o_entry
);

    logic [5:0]   w_op;
    logic [5:0]   w_fn;
    logic [4:0]   w_rt;
    logic [4:0]   w_rd;
    logic [4:0]   w_sh;
    logic [15:0]  w_imm;
    logic         w_unused_rs_field;
    logic         w_legal;
    logic         w_writes;
    issue_entry_t w_e;

    assign w_op  = i_instr[31:26];
    assign w_rt  = i_instr[20:16];
    assign w_rd  = i_instr[15:11];
    assign w_sh  = i_instr[10:6];
    assign w_fn  = i_instr[5:0];
    assign w_imm = i_instr[15:0];
    // rs arrives already read from the register file; its index is not needed here
    assign w_unused_rs_field = ^i_instr[25:21];

    always_comb begin
        w_e      = '0;
        w_legal  = 1'b1;
        w_writes = 1'b1;
        w_e.a    = i_rs_data;
        w_e.b    = i_rt_data;
        w_e.dst  = w_rd;
        case (w_op)
            OP_RTYPE: begin
                case (w_fn)
                    FN_ADDU: w_e.aluop = ALUOP_ADD;
                    FN_SUBU: w_e.aluop = ALUOP_SUB;
                    FN_AND:  w_e.aluop = ALUOP_AND;
                    FN_OR:   w_e.aluop = ALUOP_OR;
                    FN_XOR:  w_e.aluop = ALUOP_XOR;
                    FN_NOR:  w_e.aluop = ALUOP_NOR;
                    FN_SLT:  w_e.aluop = ALUOP_SLT;
                    // shifts: A carries the amount, B the value being shifted
                    FN_SLL:  begin w_e.aluop = ALUOP_SLL; w_e.a = {27'b0, w_sh}; end
                    FN_SRL:  begin w_e.aluop = ALUOP_SRL; w_e.a = {27'b0, w_sh}; end
                    FN_SRA:  begin w_e.aluop = ALUOP_SRA; w_e.a = {27'b0, w_sh}; end
                    FN_SLLV: begin w_e.aluop = ALUOP_SLL; w_e.a = {27'b0, i_rs_data[4:0]}; end
                    FN_SRLV: begin w_e.aluop = ALUOP_SRL; w_e.a = {27'b0, i_rs_data[4:0]}; end
                    FN_SRAV: begin w_e.aluop = ALUOP_SRA; w_e.a = {27'b0, i_rs_data[4:0]}; end
                    default: w_legal = 1'b0;
                endcase
            end
            OP_ADDIU: begin w_e.aluop = ALUOP_ADD; w_e.b = sext16(w_imm); w_e.dst = w_rt; end
            OP_SLTI:  begin w_e.aluop = ALUOP_SLT; w_e.b = sext16(w_imm); w_e.dst = w_rt; end
            OP_ANDI:  begin w_e.aluop = ALUOP_AND; w_e.b = zext16(w_imm); w_e.dst = w_rt; end
            OP_ORI:   begin w_e.aluop = ALUOP_OR;  w_e.b = zext16(w_imm); w_e.dst = w_rt; end
            OP_XORI:  begin w_e.aluop = ALUOP_XOR; w_e.b = zext16(w_imm); w_e.dst = w_rt; end
            OP_LUI: begin
                w_e.aluop = ALUOP_SLL;
                w_e.a     = 32'd16;
                w_e.b     = zext16(w_imm);
                w_e.dst   = w_rt;
            end
            OP_LW:    begin w_e.aluop = ALUOP_ADD; w_e.b = sext16(w_imm); w_e.dst = w_rt; end
            OP_SW: begin
                w_e.aluop = ALUOP_ADD;
                w_e.b     = sext16(w_imm);
                w_e.dst   = 5'd0;
                w_writes  = 1'b0;
            end
            OP_BEQ, OP_BNE: begin
                w_e.aluop = ALUOP_SUB;
                w_e.dst   = 5'd0;
                w_writes  = 1'b0;
            end
            default: w_legal = 1'b0;
        endcase
        if (!w_legal) begin
            w_e         = '0;
            w_e.illegal = 1'b1;
        end else begin
            w_e.wen = w_writes && (w_e.dst != 5'd0);
        end
    end

    assign o_entry = w_e;

endmodule

// File: rtl/alu_issue_stage.sv
// Decode/issue stage feeding the ALU: decoded entries pass through a main + skid
// register pair so in_ready can be a flop with no path from out_ready.
module alu_issue_stage (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    alu_issue_stage_if.slave  bus
);
    import alu_pkg::*;

    issue_entry_t w_dec;
    issue_entry_t r_main;
    issue_entry_t r_skid;
    logic         r_main_vld;
    logic         r_skid_vld;
    logic         r_in_ready;
    logic         w_accept;
    logic         w_issue;

    alu_op_decode u_dec (
        .i_instr   (bus.in_instr),
        .i_rs_data (bus.in_rs_data),
        .i_rt_data (bus.in_rt_data),
        .o_entry   (w_dec)
    );

    assign w_accept = bus.in_valid && r_in_ready;
    assign w_issue  = r_main_vld && bus.out_ready;

    // r_in_ready is always the inverse of r_skid_vld; kept as its own flop for timing
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_main     <= '0;
            r_skid     <= '0;
            r_main_vld <= 1'b0;
            r_skid_vld <= 1'b0;
            r_in_ready <= 1'b1;
        end else if (flush) begin
            // an issue coinciding with flush already completed on the consumer side
            r_main_vld <= 1'b0;
            r_skid_vld <= 1'b0;
            r_in_ready <= 1'b1;
        end else if (w_issue) begin
            if (r_skid_vld) begin
                r_main     <= r_skid;
                r_skid_vld <= 1'b0;
                r_in_ready <= 1'b1;
            end else if (w_accept) begin
                r_main <= w_dec;
            end else begin
                r_main_vld <= 1'b0;
            end
        end else if (w_accept) begin
            if (!r_main_vld) begin
                r_main     <= w_dec;
                r_main_vld <= 1'b1;
            end else begin
                r_skid     <= w_dec;
                r_skid_vld <= 1'b1;
                r_in_ready <= 1'b0;
            end
        end
    end

    assign bus.in_ready    = r_in_ready;
    assign bus.out_valid   = r_main_vld;
    assign bus.out_a       = r_main.a;
    assign bus.out_b       = r_main.b;
    assign bus.out_aluop   = r_main.aluop;
    assign bus.out_dst     = r_main.dst;
    assign bus.out_wen     = r_main.wen;
    assign bus.out_illegal = r_main.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: directed decode/handshake cases, then random traffic
// checked against an instruction-level reference model.
module tb_alu_issue_stage;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic [4:0]  dst;
        logic        wen;
        logic        ill;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic flush;
    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t q[$];

    logic [5:0] i_ops [12] = '{6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F,
                               6'h23, 6'h2B, 6'h04, 6'h05, 6'h3F, 6'h02};
    logic [5:0] r_fns [14] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h21,
                               6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h08};

    alu_issue_stage_if bus ();

    alu_issue_stage dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: what the ALU must be told to do for each MIPS instruction
    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt);
        exp_t        e;
        logic [5:0]  op = ins[31:26];
        logic [5:0]  fn = ins[5:0];
        logic [31:0] se = {{16{ins[15]}}, ins[15:0]};
        logic [31:0] ze = {16'h0, ins[15:0]};
        logic [31:0] shamt = {27'b0, ins[10:6]};
        logic [31:0] vamt = rs & 32'd31;
        bit          ok = 1;
        bit          writes = 1;
        e = '0;
        if (op == 6'h00) begin
            e.a = rs; e.b = rt; e.dst = ins[15:11];
            case (fn)
                6'h21: e.op = 4'd2;
                6'h23: e.op = 4'd3;
                6'h24: e.op = 4'd0;
                6'h25: e.op = 4'd1;
                6'h26: e.op = 4'd6;
                6'h27: e.op = 4'd5;
                6'h2A: e.op = 4'd4;
                6'h00: begin e.op = 4'd7; e.a = shamt; end
                6'h02: begin e.op = 4'd8; e.a = shamt; end
                6'h03: begin e.op = 4'd9; e.a = shamt; end
                6'h04: begin e.op = 4'd7; e.a = vamt; end
                6'h06: begin e.op = 4'd8; e.a = vamt; end
                6'h07: begin e.op = 4'd9; e.a = vamt; end
                default: ok = 0;
            endcase
        end else begin
            e.a = rs; e.dst = ins[20:16];
            case (op)
                6'h09: begin e.op = 4'd2; e.b = se; end
                6'h0A: begin e.op = 4'd4; e.b = se; end
                6'h0C: begin e.op = 4'd0; e.b = ze; end
                6'h0D: begin e.op = 4'd1; e.b = ze; end
                6'h0E: begin e.op = 4'd6; e.b = ze; end
                6'h0F: begin e.op = 4'd7; e.a = 32'd16; e.b = ze; end
                6'h23: begin e.op = 4'd2; e.b = se; end
                6'h2B: begin e.op = 4'd2; e.b = se; e.dst = 0; writes = 0; end
                6'h04, 6'h05: begin e.op = 4'd3; e.b = rt; e.dst = 0; writes = 0; end
                default: ok = 0;
            endcase
        end
        if (!ok) begin
            e = '0;
            e.ill = 1'b1;
        end else begin
            e.wen = writes && (e.dst != 0);
        end
        return e;
    endfunction

    function automatic logic [31:0] gen_instr();
        int k = $urandom_range(0, 3);
        logic [31:0] w = $urandom;
        if (k == 1 || k == 2) return {6'h00, w[25:6], r_fns[$urandom_range(0, 13)]};
        if (k == 3)           return {i_ops[$urandom_range(0, 11)], w[25:0]};
        return w;
    endfunction

    // Monitor at negedge: verify state left by the last edge, then predict the next edge
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            chk("rst_out_valid", bus.out_valid, 0);
            chk("rst_in_ready", bus.in_ready, 1);
            chk("rst_out_a", bus.out_a, 0);
            chk("rst_out_b", bus.out_b, 0);
            chk("rst_out_ctl", {bus.out_aluop, bus.out_dst, bus.out_wen, bus.out_illegal}, 0);
        end else begin
            chk("out_valid", bus.out_valid, q.size() > 0);
            chk("in_ready", bus.in_ready, q.size() < 2);
            if (bus.out_valid && q.size() > 0) begin
                chk("out_a", bus.out_a, q[0].a);
                chk("out_b", bus.out_b, q[0].b);
                chk("out_aluop", bus.out_aluop, q[0].op);
                chk("out_dst", bus.out_dst, q[0].dst);
                chk("out_wen", bus.out_wen, q[0].wen);
                chk("out_illegal", bus.out_illegal, q[0].ill);
            end
            if (bus.out_valid && bus.out_ready && q.size() > 0) void'(q.pop_front());
            if (flush) q.delete();
            else if (bus.in_valid && bus.in_ready)
                q.push_back(model(bus.in_instr, bus.in_rs_data, bus.in_rt_data));
        end
    end

    task automatic push(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt);
        bus.in_valid = 1'b1; bus.in_instr = ins; bus.in_rs_data = rs; bus.in_rt_data = rt;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                @(posedge clk); #1;
                bus.in_valid = 1'b0;
                return;
            end
        end
        chk("push_timeout", 1, 0);
        bus.in_valid = 1'b0;
    endtask

    task automatic expect_out(input string nm, input logic [31:0] a, input logic [31:0] b,
                              input logic [3:0] op, input logic [4:0] dst, input logic wen, input logic ill);
        @(negedge clk);
        chk({nm, "_valid"}, bus.out_valid, 1);
        chk({nm, "_a"}, bus.out_a, a);
        chk({nm, "_b"}, bus.out_b, b);
        chk({nm, "_aluop"}, bus.out_aluop, op);
        chk({nm, "_dst"}, bus.out_dst, dst);
        chk({nm, "_wen_ill"}, {bus.out_wen, bus.out_illegal}, {wen, ill});
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        bus.in_instr = '0; bus.in_rs_data = '0; bus.in_rt_data = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Directed decode cases
        push(32'h2422FFFF, 32'd5, 32'd0);
        expect_out("addiu", 32'h5, 32'hFFFFFFFF, 4'b0010, 5'd2, 1'b1, 1'b0);
        push(32'h3C031234, 32'd7, 32'd9);
        expect_out("lui", 32'd16, 32'h00001234, 4'b0111, 5'd3, 1'b1, 1'b0);
        push(32'h000520C3, 32'd1, 32'h80000000);
        expect_out("sra", 32'd3, 32'h80000000, 4'b1001, 5'd4, 1'b1, 1'b0);
        push(32'hFC000000, 32'd1, 32'd2);
        expect_out("illegal", 32'd0, 32'd0, 4'b0000, 5'd0, 1'b0, 1'b1);
        push(32'hAC220004, 32'h100, 32'd2);
        expect_out("sw", 32'h100, 32'h4, 4'b0010, 5'd0, 1'b0, 1'b0);
        @(posedge clk); #1;

        // Backpressure: 4 instructions, consumer stalled 3 cycles
        bus.out_ready = 1'b0;
        push(32'h00221821, 32'd10, 32'd20);
        chk("bp_in_ready_1", bus.in_ready, 1);
        push(32'h00221823, 32'd30, 32'd4);
        chk("bp_in_ready_2", bus.in_ready, 0);
        fork
            begin
                push(32'h3443ABCD, 32'h0F0F0000, 32'd0);
                push(32'h00221825, 32'hA5A5A5A5, 32'h5A5A5A5A);
            end
        join_none
        repeat (3) @(posedge clk);
        #1 bus.out_ready = 1'b1;
        wait fork;
        repeat (4) @(posedge clk);
        #1;

        // Flush with skid full and a new instruction offered
        bus.out_ready = 1'b0;
        push(32'h24210001, 32'd1, 32'd0);
        push(32'h24420002, 32'd2, 32'd0);
        bus.in_valid = 1'b1; bus.in_instr = 32'h24630003; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; bus.in_valid = 1'b0;
        chk("flush_out_valid", bus.out_valid, 0);
        chk("flush_in_ready", bus.in_ready, 1);
        bus.out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // Asynchronous reset in the middle of a stall
        bus.out_ready = 1'b0;
        push(32'h00A62024, 32'hFF, 32'h0F);
        push(32'h00A62027, 32'hFF, 32'h0F);
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", bus.out_valid, 0);
        chk("midrst_in_ready", bus.in_ready, 1);
        @(posedge clk); #1;
        rst = 1'b0; bus.out_ready = 1'b1;
        @(posedge clk); #1;

        // Random traffic with occasional flush
        for (int c = 0; c < 3000; c++) begin
            bus.in_valid   = ($urandom_range(0, 3) != 0);
            bus.in_instr   = gen_instr();
            bus.in_rs_data = $urandom;
            bus.in_rt_data = ($urandom_range(0, 3) == 0) ? 32'h80000000 : $urandom;
            bus.out_ready  = ($urandom_range(0, 2) != 0);
            flush          = ($urandom_range(0, 24) == 0);
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0; flush = 1'b0; bus.out_ready = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("drain_empty", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
